// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side valid/ready bundle for the RV32I decode stage.
// slave = the decode stage itself; master = whatever drives fetch and sinks execute.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_instruction;
    logic [XLEN-1:0] i_pc;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_pc;
    logic [6:0]      o_opcode;
    logic [6:0]      o_funct7;
    logic [2:0]      o_funct3;
    logic [4:0]      o_rs1;
    logic [4:0]      o_rs2;
    logic [4:0]      o_rd;
    logic [XLEN-1:0] o_imm;
    logic [2:0]      o_inst_type;
    logic            o_illegal;
    logic            o_is_muldiv;

    modport slave (
        input  i_valid, i_instruction, i_pc, i_ready,
        output o_ready, o_valid, o_pc, o_opcode, o_funct7, o_funct3,
               o_rs1, o_rs2, o_rd, o_imm, o_inst_type, o_illegal, o_is_muldiv
    );

    modport master (
        output i_valid, i_instruction, i_pc, i_ready,
        input  o_ready, o_valid, o_pc, o_opcode, o_funct7, o_funct3,
               o_rs1, o_rs2, o_rd, o_imm, o_inst_type, o_illegal, o_is_muldiv
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes on push, buffers results in a DEPTH-entry in-order queue.
// Optional feature macro DECODE_M_EXT_EN accepts M-extension R-type ops and flags them via o_is_muldiv.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           i_flush,
    decode_stage_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        T_ERROR = 3'd0,
        T_R     = 3'd1,
        T_I     = 3'd2,
        T_S     = 3'd3,
        T_B     = 3'd4,
        T_U     = 3'd5,
        T_J     = 3'd6
    } inst_type_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [6:0]      funct7;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        inst_type_e      itype;
        logic            illegal;
        logic            muldiv;
    } entry_t;

    logic [31:0]       inst;
    logic [6:0]        f7;
    logic [2:0]        f3;
    logic              r_legal;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [20:0] imm_j;
    logic signed [31:0] imm_u;
    entry_t            dec;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    entry_t            head;
    entry_t            shown;

    assign inst  = bus.i_instruction;
    assign f7    = inst[31:25];
    assign f3    = inst[14:12];
    assign imm_i = inst[31:20];
    assign imm_s = {inst[31:25], inst[11:7]};
    assign imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};

`ifdef DECODE_M_EXT_EN
    assign r_legal = (f7 == 7'b0000000) || (f7 == 7'b0000001) ||
                     ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
`else
    assign r_legal = (f7 == 7'b0000000) ||
                     ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
`endif

    // Illegal encodings leave every decoded field at zero; only the pc and the flag survive.
    always_comb begin
        dec       = '0;
        dec.pc    = bus.i_pc;
        dec.itype = T_ERROR;
        case (inst[6:0])
            7'b0110011: if (r_legal) begin
                dec.itype  = T_R;
                dec.funct7 = f7;
                dec.funct3 = f3;
                dec.rs1    = inst[19:15];
                dec.rs2    = inst[24:20];
                dec.rd     = inst[11:7];
`ifdef DECODE_M_EXT_EN
                dec.muldiv = (f7 == 7'b0000001);
`endif
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec.itype  = T_I;
                dec.funct3 = f3;
                dec.rs1    = inst[19:15];
                dec.rd     = inst[11:7];
                dec.imm    = XLEN'(imm_i);
            end
            7'b0100011: begin
                dec.itype  = T_S;
                dec.funct3 = f3;
                dec.rs1    = inst[19:15];
                dec.rs2    = inst[24:20];
                dec.imm    = XLEN'(imm_s);
            end
            7'b1100011: begin
                dec.itype  = T_B;
                dec.funct3 = f3;
                dec.rs1    = inst[19:15];
                dec.rs2    = inst[24:20];
                dec.imm    = XLEN'(imm_b);
            end
            7'b0110111, 7'b0010111: begin
                dec.itype  = T_U;
                dec.rd     = inst[11:7];
                dec.imm    = XLEN'(imm_u);
            end
            7'b1101111: begin
                dec.itype  = T_J;
                dec.rd     = inst[11:7];
                dec.imm    = XLEN'(imm_j);
            end
            default: dec.itype = T_ERROR;
        endcase
        if (dec.itype == T_ERROR) begin
            dec.illegal = 1'b1;
        end else begin
            dec.opcode = inst[6:0];
        end
    end

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus.o_ready = (count < CNT_W'(DEPTH));
    assign bus.o_valid = (count != '0);
    assign push = bus.i_valid & bus.o_ready & clk_en & ~i_flush;
    assign pop  = bus.o_valid & bus.i_ready & clk_en;

    // Flush outranks push and pop; reset outranks everything including clk_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clk_en) begin
            if (i_flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_next(wr_ptr);
                if (pop)  rd_ptr <= ptr_next(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign head  = mem[rd_ptr];
    assign shown = bus.o_valid ? head : '0;

    assign bus.o_pc        = shown.pc;
    assign bus.o_opcode    = shown.opcode;
    assign bus.o_funct7    = shown.funct7;
    assign bus.o_funct3    = shown.funct3;
    assign bus.o_rs1       = shown.rs1;
    assign bus.o_rs2       = shown.rs2;
    assign bus.o_rd        = shown.rd;
    assign bus.o_imm       = shown.imm;
    assign bus.o_inst_type = shown.itype;
    assign bus.o_illegal   = shown.illegal;
    assign bus.o_is_muldiv = shown.muldiv;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: queue-based reference model checked every cycle, plus literal spot checks.
module tb_decode_stage;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    logic i_flush;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN)) bus ();

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .i_flush (i_flush),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [2:0]  itype;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
        logic        muldiv;
    } exp_t;

    exp_t        q[$];
    exp_t        exp_head;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          check_en = 1'b0;
    bit          m_push;
    bit          m_pop;
    logic [31:0] pc_ctr;

    // Reference decode computed from field positions with integer arithmetic.
    function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   s;
        int   t;
        bit   m_ext;
        logic [6:0] f7;
        logic [2:0] f3;
        e = '{default: '0};
        s = int'(w);
        f7 = w[31:25];
        f3 = w[14:12];
`ifdef DECODE_M_EXT_EN
        m_ext = 1'b1;
`else
        m_ext = 1'b0;
`endif
        case (w[6:0])
            7'b0110011: t = (f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                             (m_ext && f7 == 7'd1)) ? 1 : 0;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: t = 2;
            7'b0100011: t = 3;
            7'b1100011: t = 4;
            7'b0110111, 7'b0010111: t = 5;
            7'b1101111: t = 6;
            default:    t = 0;
        endcase
        e.pc    = pc;
        e.itype = t[2:0];
        if (t == 0) begin
            e.illegal = 1'b1;
            return e;
        end
        e.opcode = w[6:0];
        if (t >= 1 && t <= 4) begin
            e.funct3 = f3;
            e.rs1    = w[19:15];
        end
        if (t == 1 || t == 3 || t == 4) e.rs2 = w[24:20];
        if (t == 1 || t == 2 || t == 5 || t == 6) e.rd = w[11:7];
        if (t == 1) begin
            e.funct7 = f7;
            e.muldiv = m_ext && (f7 == 7'd1);
        end
        case (t)
            2: e.imm = s >>> 20;
            3: e.imm = ((s >>> 25) * 32) + ((s >> 7) & 31);
            4: e.imm = ((s >>> 31) * 4096) + (((s >> 7) & 1) * 2048) +
                       (((s >> 25) & 63) * 32) + (((s >> 8) & 15) * 2);
            5: e.imm = w & 32'hFFFFF000;
            6: e.imm = ((s >>> 31) * 1048576) + (((s >> 12) & 255) * 4096) +
                       (((s >> 20) & 1) * 2048) + (((s >> 21) & 1023) * 2);
            default: e.imm = '0;
        endcase
        return e;
    endfunction

    function automatic logic [127:0] pack_exp(input exp_t e);
        return 128'({e.pc, e.imm, e.opcode, e.funct7, e.funct3, e.rs1, e.rs2, e.rd,
                     e.itype, e.illegal, e.muldiv});
    endfunction

    function automatic logic [127:0] pack_dut();
        return 128'({bus.o_pc, bus.o_imm, bus.o_opcode, bus.o_funct7, bus.o_funct3,
                     bus.o_rs1, bus.o_rs2, bus.o_rd, bus.o_inst_type, bus.o_illegal,
                     bus.o_is_muldiv});
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the falling edge and are held across exactly one rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic rdy, input logic en, input logic fl, input logic r);
        #1;
        bus.i_valid       = v;
        bus.i_instruction = ins;
        bus.i_pc          = pc;
        bus.i_ready       = rdy;
        clk_en            = en;
        i_flush           = fl;
        rst               = r;
        @(negedge clk);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        if ($urandom_range(0, 9) < 7) begin
            k = $urandom_range(0, 9);
            case (k)
                0: w[6:0] = 7'b0110011;
                1: w[6:0] = 7'b0010011;
                2: w[6:0] = 7'b0000011;
                3: w[6:0] = 7'b1100111;
                4: w[6:0] = 7'b1110011;
                5: w[6:0] = 7'b0100011;
                6: w[6:0] = 7'b1100011;
                7: w[6:0] = 7'b0110111;
                8: w[6:0] = 7'b0010111;
                default: w[6:0] = 7'b1101111;
            endcase
            if (k == 0 && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 2))
                    0: w[31:25] = 7'b0000000;
                    1: w[31:25] = 7'b0100000;
                    default: w[31:25] = 7'b0000001;
                endcase
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else if (clk_en) begin
            if (i_flush) begin
                q.delete();
            end else begin
                m_push = bus.i_valid && (q.size() < DEPTH);
                m_pop  = (q.size() != 0) && bus.i_ready;
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back(model_decode(bus.i_instruction, bus.i_pc));
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("o_valid", 128'(bus.o_valid), 128'(q.size() != 0));
            checkOutput("o_ready", 128'(bus.o_ready), 128'(q.size() < DEPTH));
            exp_head = (q.size() != 0) ? q[0] : '{default: '0};
            checkOutput("head_fields", pack_dut(), pack_exp(exp_head));
        end
    end

    initial begin
        rst               = 1'b1;
        clk_en            = 1'b1;
        i_flush           = 1'b0;
        bus.i_valid       = 1'b0;
        bus.i_ready       = 1'b0;
        bus.i_instruction = '0;
        bus.i_pc          = '0;
        @(negedge clk);
        check_en = 1'b1;

        applyStimulus(0, 32'h0, 32'h0, 0, 1, 0, 1);
        checkOutput("rst_valid", 128'(bus.o_valid), 128'd0);
        checkOutput("rst_ready", 128'(bus.o_ready), 128'd1);
        checkOutput("rst_fields", pack_dut(), 128'd0);

        // addi x1,x0,-1
        applyStimulus(1, 32'hFFF00093, 32'h100, 0, 1, 0, 0);
        checkOutput("addi_valid", 128'(bus.o_valid), 128'd1);
        checkOutput("addi_type", 128'(bus.o_inst_type), 128'd2);
        checkOutput("addi_rd", 128'(bus.o_rd), 128'd1);
        checkOutput("addi_rs1", 128'(bus.o_rs1), 128'd0);
        checkOutput("addi_imm", 128'(bus.o_imm), 128'hFFFFFFFF);
        checkOutput("addi_illegal", 128'(bus.o_illegal), 128'd0);
        applyStimulus(0, 32'h0, 32'h0, 1, 1, 0, 0);

        // beq x0,x0,-4
        applyStimulus(1, 32'hFE000EE3, 32'h104, 0, 1, 0, 0);
        checkOutput("beq_type", 128'(bus.o_inst_type), 128'd4);
        checkOutput("beq_imm", 128'(bus.o_imm), 128'hFFFFFFFC);
        checkOutput("beq_rd", 128'(bus.o_rd), 128'd0);
        checkOutput("beq_funct3", 128'(bus.o_funct3), 128'd0);
        applyStimulus(0, 32'h0, 32'h0, 1, 1, 0, 0);

        // Illegal encodings are still delivered, with zeroed fields.
        applyStimulus(1, 32'h00000000, 32'h108, 0, 1, 0, 0);
        checkOutput("zero_valid", 128'(bus.o_valid), 128'd1);
        checkOutput("zero_illegal", 128'(bus.o_illegal), 128'd1);
        checkOutput("zero_type", 128'(bus.o_inst_type), 128'd0);
        checkOutput("zero_pc", 128'(bus.o_pc), 128'h108);
        applyStimulus(1, 32'h40001033, 32'h10C, 1, 1, 0, 0);
        checkOutput("sub_f3_illegal", 128'(bus.o_illegal), 128'd1);
        checkOutput("sub_f3_type", 128'(bus.o_inst_type), 128'd0);
        checkOutput("sub_f3_rd", 128'(bus.o_rd), 128'd0);
        checkOutput("sub_f3_funct7", 128'(bus.o_funct7), 128'd0);
        applyStimulus(0, 32'h0, 32'h0, 1, 1, 0, 0);

        // mul x3,x1,x2
        applyStimulus(1, 32'h022081B3, 32'h110, 0, 1, 0, 0);
`ifdef DECODE_M_EXT_EN
        checkOutput("mul_type", 128'(bus.o_inst_type), 128'd1);
        checkOutput("mul_muldiv", 128'(bus.o_is_muldiv), 128'd1);
        checkOutput("mul_regs", 128'({bus.o_rs1, bus.o_rs2, bus.o_rd}), 128'({5'd1, 5'd2, 5'd3}));
`else
        checkOutput("mul_illegal", 128'(bus.o_illegal), 128'd1);
        checkOutput("mul_muldiv", 128'(bus.o_is_muldiv), 128'd0);
`endif
        applyStimulus(0, 32'h0, 32'h0, 1, 1, 0, 0);

        // Back-pressure with DEPTH=2: third push refused until a slot frees up.
        applyStimulus(1, 32'h00000013, 32'h0, 0, 1, 0, 0);
        applyStimulus(1, 32'h00000013, 32'h4, 0, 1, 0, 0);
        checkOutput("full_ready", 128'(bus.o_ready), 128'd0);
        applyStimulus(1, 32'h00000013, 32'h8, 0, 1, 0, 0);
        checkOutput("full_head_pc", 128'(bus.o_pc), 128'h0);
        applyStimulus(1, 32'h00000013, 32'h8, 1, 1, 0, 0);
        checkOutput("drain_pc1", 128'(bus.o_pc), 128'h4);
        checkOutput("drain_ready", 128'(bus.o_ready), 128'd1);
        applyStimulus(1, 32'h00000013, 32'h8, 1, 1, 0, 0);
        checkOutput("drain_pc2", 128'(bus.o_pc), 128'h8);
        applyStimulus(0, 32'h0, 32'h0, 1, 1, 0, 0);
        checkOutput("drain_empty", 128'(bus.o_valid), 128'd0);

        // clk_en=0 freezes everything, including a pending pop.
        applyStimulus(1, 32'h00500113, 32'h20, 0, 1, 0, 0);
        applyStimulus(1, 32'h00000013, 32'h24, 1, 0, 0, 0);
        checkOutput("hold_pc", 128'(bus.o_pc), 128'h20);
        applyStimulus(0, 32'h0, 32'h0, 1, 1, 0, 0);

        // Flush with a same-cycle push, then reset with clk_en low.
        applyStimulus(1, 32'h00000013, 32'h30, 0, 1, 0, 0);
        applyStimulus(1, 32'h00000013, 32'h34, 0, 1, 0, 0);
        applyStimulus(1, 32'h00000013, 32'h38, 0, 1, 1, 0);
        checkOutput("flush_valid", 128'(bus.o_valid), 128'd0);
        checkOutput("flush_ready", 128'(bus.o_ready), 128'd1);
        applyStimulus(1, 32'h00000013, 32'h40, 0, 1, 0, 0);
        applyStimulus(1, 32'h00000013, 32'h44, 0, 1, 0, 0);
        applyStimulus(1, 32'h00000013, 32'h48, 1, 0, 0, 1);
        checkOutput("rst_noen_valid", 128'(bus.o_valid), 128'd0);
        checkOutput("rst_noen_ready", 128'(bus.o_ready), 128'd1);

        pc_ctr = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 70, gen_instr(), pc_ctr,
                          $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 90,
                          $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
            pc_ctr = pc_ctr + 32'd4;
        end

        applyStimulus(0, 32'h0, 32'h0, 1, 1, 0, 0);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
